// File: rtl/decade_count_capture_if.sv
// Snapshot handshake bundle for decade_count_capture.
// The master modport is the snapshot producer and the slave modport is the consumer.
interface decade_count_capture_if #(
  parameter int DIGITS = 4
);
  logic                snap_req_i;
  logic                snap_ready_i;
  logic                snap_valid_o;
  logic [4*DIGITS-1:0] snap_bcd_o;

  modport master (
    input  snap_req_i,
    input  snap_ready_i,
    output snap_valid_o,
    output snap_bcd_o
  );

  modport slave (
    output snap_req_i,
    output snap_ready_i,
    input  snap_valid_o,
    input  snap_bcd_o
  );
endinterface

// File: rtl/decade_count_capture.sv
// Captures an asynchronous mod-10 ripple counter, extends it with BCD decade digits
// and serves snapshots over valid/ready. Optional macro OVERFLOW_SAT_EN saturates on overflow.
module decade_count_capture #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic [3:0]             cnt_i,
  input  logic                   clr_i,
  decade_count_capture_if.master snap,
  output logic                   carry_o,
  output logic                   ovf_o,
  output logic                   err_o
);
  localparam int UW = 4*(DIGITS-1);
  localparam int MW = $clog2(STABLE_CNT+1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [3:0]          sync_p0 [SYNC_STAGES];
  logic [3:0]          sync_q;
  logic [3:0]          cand_p1;
  logic [MW-1:0]       match_p1;
  logic                vld_p1;
  logic                cand_illegal;
  logic                wrap;
  logic [3:0]          stable_p2;
  logic [UW-1:0]       upper_p2;
  logic [UW:0]         inc_p2;
  logic [4*DIGITS-1:0] snap_val;
  logic [4*DIGITS-1:0] snap_bcd_q;
  logic                load_snap;
  state_t              state_q, state_d;

  // BCD increment of the upper digits; MSB of the result is the carry out of the top digit.
  function automatic logic [UW:0] bcd_inc(input logic [UW-1:0] d);
    logic [UW-1:0] r;
    logic          c;
    r = d;
    c = 1'b1;
    for (int i = 0; i < DIGITS-1; i++) begin
      if (c) begin
        if (d[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Stage p0: synchroniser chain
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= 4'd0;
    end else begin
      sync_p0[0] <= cnt_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

  assign sync_q = sync_p0[SYNC_STAGES-1];

  // Stage p1: glitch filter
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cand_p1  <= 4'd0;
      match_p1 <= '0;
    end else begin
      cand_p1 <= sync_q;
      if (sync_q != cand_p1)
        match_p1 <= MW'(1);
      else if (match_p1 != MW'(STABLE_CNT))
        match_p1 <= match_p1 + MW'(1);
    end
  end

  assign vld_p1       = (match_p1 == MW'(STABLE_CNT)) && (cand_p1 != stable_p2);
  assign cand_illegal = vld_p1 && (cand_p1 > 4'd9);
  assign wrap         = vld_p1 && !cand_illegal && (cand_p1 < stable_p2);
  assign inc_p2       = bcd_inc(upper_p2);

  // Stage p2: live digit, decade accumulator and sticky flags
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= 4'd0;
      upper_p2  <= '0;
      carry_o   <= 1'b0;
      ovf_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (vld_p1 && !cand_illegal) stable_p2 <= cand_p1;
      carry_o <= wrap;
      if (clr_i) begin
        upper_p2 <= '0;
        ovf_o    <= 1'b0;
        err_o    <= 1'b0;
      end else begin
        if (cand_illegal) err_o <= 1'b1;
        if (wrap) begin
          if (inc_p2[UW]) begin
            ovf_o <= 1'b1;
`ifdef OVERFLOW_SAT_EN
            upper_p2 <= upper_p2;
`else
            upper_p2 <= inc_p2[UW-1:0];
`endif
          end else begin
            upper_p2 <= inc_p2[UW-1:0];
          end
        end
      end
    end
  end

`ifdef OVERFLOW_SAT_EN
  assign snap_val = ovf_o ? {DIGITS{4'd9}} : {upper_p2, stable_p2};
`else
  assign snap_val = {upper_p2, stable_p2};
`endif

  // Snapshot FSM
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      snap_bcd_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_snap) snap_bcd_q <= snap_val;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_snap = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap.snap_req_i) begin
          load_snap = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (snap.snap_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign snap.snap_valid_o = (state_q == HOLD);
  assign snap.snap_bcd_o   = snap_bcd_q;
endmodule

// File: tb/tb_decade_count_capture.sv
// Directed bench for decade_count_capture: filter, wraps, errors, overflow and snapshot handshake.
module tb_decade_count_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cnt = 4'd0;
  logic        clr = 1'b0;
  logic        carry_o, ovf_o, err_o;
  int          total = 0;
  int          bad = 0;
  int          carry_seen = 0;

  decade_count_capture_if #(.DIGITS(4)) sif ();

  decade_count_capture #(.DIGITS(4), .SYNC_STAGES(2), .STABLE_CNT(2)) dut (
    .clk_i   (clk),
    .rst_n   (rst_n),
    .cnt_i   (cnt),
    .clr_i   (clr),
    .snap    (sif),
    .carry_o (carry_o),
    .ovf_o   (ovf_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (carry_o) carry_seen++;
    end
  endtask

  task automatic apply(input logic [3:0] v, input int n);
    cnt = v;
    tick(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cnt = 4'd0;
    clr = 1'b0;
    sif.snap_req_i = 1'b0;
    sif.snap_ready_i = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    carry_seen = 0;
  endtask

  // Full request/accept cycle; ok=0 if valid never rose within the bound.
  task automatic snapshot(output logic [15:0] v, output bit ok);
    ok = 1'b0;
    v = '0;
    sif.snap_req_i = 1'b1;
    tick(1);
    sif.snap_req_i = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      if (sif.snap_valid_o) begin
        ok = 1'b1;
        v = sif.snap_bcd_o;
      end else begin
        tick(1);
      end
    end
    sif.snap_ready_i = 1'b1;
    tick(1);
    sif.snap_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    sif.snap_req_i = 1'b0;
    sif.snap_ready_i = 1'b0;
    #2;
    total++;
    if ({sif.snap_valid_o, carry_o, ovf_o, err_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {sif.snap_valid_o, carry_o, ovf_o, err_o});
    end
    total++;
    if (sif.snap_bcd_o !== 16'h0000) begin
      bad++;
      $display("FAIL reset_bcd: got %h want 0000", sif.snap_bcd_o);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_count();
    int seq [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3};
    int first;
    logic [15:0] v;
    bit ok;
    do_reset();
    first = -1;
    for (int k = 0; k < 14; k++) begin
      cnt = 4'(seq[k]);
      for (int c = 1; c <= 8; c++) begin
        tick(1);
        if (carry_o && k == 10 && first < 0) first = c;
      end
    end
    total++;
    if (first < 4 || first > 5) begin
      bad++;
      $display("FAIL carry_latency: got %0d clk want 4..5", first);
    end
    total++;
    if (carry_seen !== 1) begin
      bad++;
      $display("FAIL carry_count: got %0d want 1", carry_seen);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h0013) begin
      bad++;
      $display("FAIL count_snap: got %h ok=%0d want 0013", v, ok);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] v;
    bit ok;
    do_reset();
    apply(4'd7, 8);
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h0007) begin
      bad++;
      $display("FAIL glitch_pre: got %h want 0007", v);
    end
    carry_seen = 0;
    apply(4'd6, 1);
    apply(4'd8, 8);
    total++;
    if (carry_seen !== 0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL glitch_flags: got carries=%0d err=%b want 0 0", carry_seen, err_o);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h0008) begin
      bad++;
      $display("FAIL glitch_snap: got %h want 0008", v);
    end
  endtask

  task automatic test_err();
    logic [15:0] v;
    bit ok;
    do_reset();
    apply(4'd5, 8);
    apply(4'hB, 8);
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_set: got %b want 1", err_o);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h0005) begin
      bad++;
      $display("FAIL err_snap: got %h want 0005", v);
    end
    apply(4'd5, 8);
    total++;
    if (err_o !== 1'b1 || carry_seen !== 0) begin
      bad++;
      $display("FAIL err_sticky: got err=%b carries=%0d want 1 0", err_o, carry_seen);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %b want 0", err_o);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    logic [15:0] exp_ovf;
    bit ok;
`ifdef OVERFLOW_SAT_EN
    exp_ovf = 16'h9999;
`else
    exp_ovf = 16'h0000;
`endif
    do_reset();
    for (int i = 0; i < 999; i++) begin
      apply(4'd5, 7);
      apply(4'd0, 7);
    end
    total++;
    if (ovf_o !== 1'b0 || carry_seen !== 999) begin
      bad++;
      $display("FAIL pre_ovf: got ovf=%b carries=%0d want 0 999", ovf_o, carry_seen);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h9990) begin
      bad++;
      $display("FAIL snap_999: got %h want 9990", v);
    end
    carry_seen = 0;
    apply(4'd9, 7);
    apply(4'd0, 7);
    total++;
    if (ovf_o !== 1'b1 || carry_seen !== 1) begin
      bad++;
      $display("FAIL ovf_set: got ovf=%b carries=%0d want 1 1", ovf_o, carry_seen);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== exp_ovf) begin
      bad++;
      $display("FAIL ovf_snap: got %h want %h", v, exp_ovf);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    snapshot(v, ok);
    total++;
    if (ovf_o !== 1'b0 || !ok || v !== 16'h0000) begin
      bad++;
      $display("FAIL ovf_clr: got ovf=%b snap=%h want 0 0000", ovf_o, v);
    end
  endtask

  task automatic test_hold();
    logic [15:0] v;
    bit ok;
    do_reset();
    apply(4'd4, 8);
    sif.snap_req_i = 1'b1;
    tick(1);
    sif.snap_req_i = 1'b0;
    total++;
    if (sif.snap_valid_o !== 1'b1 || sif.snap_bcd_o !== 16'h0004) begin
      bad++;
      $display("FAIL hold_start: got v=%b d=%h want 1 0004", sif.snap_valid_o, sif.snap_bcd_o);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 2) cnt = 4'd6;
      sif.snap_req_i = (i == 5);
      tick(1);
      total++;
      if (sif.snap_valid_o !== 1'b1 || sif.snap_bcd_o !== 16'h0004) begin
        bad++;
        $display("FAIL hold_cyc%0d: got v=%b d=%h want 1 0004", i, sif.snap_valid_o, sif.snap_bcd_o);
      end
    end
    sif.snap_req_i = 1'b1;
    sif.snap_ready_i = 1'b1;
    tick(1);
    sif.snap_req_i = 1'b0;
    sif.snap_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sif.snap_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL hold_drop%0d: got valid=%b want 0", i, sif.snap_valid_o);
      end
      tick(1);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h0006) begin
      bad++;
      $display("FAIL hold_next: got %h want 0006", v);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [15:0] v;
    bit ok;
    do_reset();
    apply(4'hB, 8);
    apply(4'd3, 8);
    sif.snap_req_i = 1'b1;
    tick(1);
    sif.snap_req_i = 1'b0;
    total++;
    if (sif.snap_valid_o !== 1'b1 || err_o !== 1'b1 || sif.snap_bcd_o !== 16'h0003) begin
      bad++;
      $display("FAIL mid_pre: got v=%b err=%b d=%h want 1 1 0003", sif.snap_valid_o, err_o, sif.snap_bcd_o);
    end
    tick(2);
    rst_n = 1'b0;
    #1;
    total++;
    if ({sif.snap_valid_o, carry_o, ovf_o, err_o} !== 4'b0000 || sif.snap_bcd_o !== 16'h0000) begin
      bad++;
      $display("FAIL mid_rst: got flags=%b d=%h want 0000 0000",
               {sif.snap_valid_o, carry_o, ovf_o, err_o}, sif.snap_bcd_o);
    end
    tick(3);
    rst_n = 1'b1;
    tick(8);
    total++;
    if (sif.snap_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle: got valid=%b want 0", sif.snap_valid_o);
    end
    snapshot(v, ok);
    total++;
    if (!ok || v !== 16'h0003) begin
      bad++;
      $display("FAIL mid_next: got %h ok=%0d want 0003", v, ok);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_glitch();
    test_err();
    test_overflow();
    test_hold();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
